sound_mixer: RTL and testbench

- Downstream of the per-event tone generators (hop, win, lose). Each generator drives a 1-bit square wave.
- Decides which source owns the single speaker pin using fixed priority. Higher index wins.
- Inserts a silent gap whenever ownership switches between sources, to suppress clicks.
- Applies a PWM volume gate and a mute, then drives the board's speaker output.

---
 rtl/sound_pkg.sv | 18 +
 rtl/src_activity.sv | 38 +++
 rtl/sound_mixer.sv | 125 ++++++++++++
 tb/tb_sound_mixer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and default constants for the speaker mixer.
package sound_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } mixState_t;

   localparam int CLK_HZ      = 50_000_000;
   localparam int ACT_TIMEOUT = 300_000;
   localparam int GAP_CYCLES  = 5_000;

   localparam int SRC_HOP  = 0;
   localparam int SRC_WIN  = 1;
   localparam int SRC_LOSE = 2;

endpackage

// File: rtl/src_activity.sv
// Per-source input register, toggle detector and activity timer.
// A source stays active for ACT_TIMEOUT cycles after its last edge.
module src_activity #(
   parameter int ACT_TIMEOUT = 300_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic srcIn,
   output logic srcQ,
   output logic active
);

   localparam int TW = $clog2(ACT_TIMEOUT + 1);
   localparam logic [TW-1:0] RELOAD = TW'(ACT_TIMEOUT);

   logic          srcPrev;
   logic          toggle;
   logic [TW-1:0] timer;

   assign toggle = srcQ ^ srcPrev;
   assign active = (timer != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         srcQ    <= 1'b0;
         srcPrev <= 1'b0;
         timer   <= '0;
      end else begin
         srcQ    <= srcIn;
         srcPrev <= srcQ;
         if (toggle)
            timer <= RELOAD;
         else if (timer != '0)
            timer <= timer - TW'(1);
      end
   end

endmodule

// File: rtl/sound_mixer.sv
// Priority arbiter for the speaker pin: highest active source index owns it,
// with a silent gap on ownership changes, then PWM volume gate and mute.
//
//   state | meaning
//   IDLE  | no source active, speaker silent
//   PLAY  | owner's square wave drives the speaker
//   GAP   | silent hold after an ownership switch
module sound_mixer #(
   parameter int N_SRC       = 3,
   parameter int ACT_TIMEOUT = sound_pkg::ACT_TIMEOUT,
   parameter int GAP_CYCLES  = sound_pkg::GAP_CYCLES,
   parameter int PWM_BITS    = 3,
   localparam int IW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_SRC-1:0]    src_sound,
   input  logic [PWM_BITS-1:0] volume,
   input  logic                mute,
   output logic                speaker_out,
   output logic [IW-1:0]       active_src,
   output logic                busy
);

   import sound_pkg::*;

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   logic [N_SRC-1:0]    srcQ;
   logic [N_SRC-1:0]    active;
   logic                anyActive;
   logic [IW-1:0]       winner;
   mixState_t           state, stateNxt;
   logic [IW-1:0]       owner, ownerNxt;
   logic [GW-1:0]       gapCnt, gapNxt;
   logic [PWM_BITS-1:0] pwmCnt;
   logic                gate;

   for (genvar g = 0; g < N_SRC; g++) begin : gSrc
      src_activity #(
         .ACT_TIMEOUT (ACT_TIMEOUT)
      ) uAct (
         .clk    (clk),
         .rst_n  (rst_n),
         .srcIn  (src_sound[g]),
         .srcQ   (srcQ[g]),
         .active (active[g])
      );
   end

   // later (higher) indices overwrite earlier ones
   always_comb begin
      winner    = '0;
      anyActive = |active;
      for (int i = 0; i < N_SRC; i++)
         if (active[i]) winner = IW'(i);
   end

   always_comb begin
      stateNxt = state;
      ownerNxt = owner;
      gapNxt   = gapCnt;
      case (state)
         IDLE: begin
            if (anyActive) begin
               stateNxt = PLAY;
               ownerNxt = winner;
            end
         end
         PLAY: begin
            if (!anyActive) begin
               stateNxt = IDLE;
               ownerNxt = '0;
            end else if (winner != owner) begin
               stateNxt = GAP;
               ownerNxt = winner;
               gapNxt   = GAP_LOAD;
            end
         end
         GAP: begin
            if (anyActive && (winner != owner)) begin
               ownerNxt = winner;
               gapNxt   = GAP_LOAD;
            end else if (gapCnt == '0) begin
               if (active[owner]) begin
                  stateNxt = PLAY;
               end else begin
                  stateNxt = IDLE;
                  ownerNxt = '0;
               end
            end else begin
               gapNxt = gapCnt - GW'(1);
            end
         end
         default: begin
            stateNxt = IDLE;
            ownerNxt = '0;
            gapNxt   = '0;
         end
      endcase
   end

   assign gate = (pwmCnt <= volume);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= '0;
         gapCnt      <= '0;
         pwmCnt      <= '0;
         speaker_out <= 1'b0;
      end else begin
         state       <= stateNxt;
         owner       <= ownerNxt;
         gapCnt      <= gapNxt;
         pwmCnt      <= pwmCnt + PWM_BITS'(1);
         speaker_out <= (state == PLAY) & srcQ[owner] & gate & ~mute;
      end
   end

   assign active_src = owner;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sound_mixer.sv
// Directed bench for sound_mixer: stimulus pushes hand-derived expectations
// into a scoreboard, a monitor process compares them at the due cycle.
module tb_sound_mixer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] src_sound = '0;
   logic [2:0] volume = 3'd7;
   logic       mute = 1'b0;
   logic       speaker_out;
   logic [1:0] active_src;
   logic       busy;

   sound_mixer #(
      .N_SRC       (3),
      .ACT_TIMEOUT (20),
      .GAP_CYCLES  (4),
      .PWM_BITS    (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .src_sound   (src_sound),
      .volume      (volume),
      .mute        (mute),
      .speaker_out (speaker_out),
      .active_src  (active_src),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // cycles since reset release; matches the DUT's free-running PWM count
   int cyc;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   typedef struct {
      int    at;    // -1: check immediately when chkEv fires
      int    sel;   // 0 speaker_out, 1 busy, 2 active_src
      int    val;
      string name;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   bit   finalChk = 1'b0;
   event chkEv;

   task automatic expectAt(input int at, input int sel, input int val, input string name);
      exp_t e;
      e.at = at; e.sel = sel; e.val = val; e.name = name;
      sb.push_back(e);
   endtask

   function automatic int observed(input int sel);
      case (sel)
         0:       return int'(speaker_out);
         1:       return int'(busy);
         default: return int'(active_src);
      endcase
   endfunction

   initial begin : monitor
      logic due;
      int   got;
      forever begin
         @(negedge clk or chkEv);
         for (int i = sb.size() - 1; i >= 0; i--) begin
            due = (sb[i].at == -1) || (rst_n && (clk == 1'b0) && (sb[i].at == cyc));
            if (due) begin
               checks++;
               got = observed(sb[i].sel);
               if (got != sb[i].val) begin
                  errors++;
                  $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                           sb[i].name, sb[i].at, got, sb[i].val);
               end
               sb.delete(i);
            end
         end
         if (finalChk) begin
            foreach (sb[i]) begin
               checks++;
               errors++;
               $display("FAIL %s at cycle %0d never compared: got nothing, expected %0d",
                        sb[i].name, sb[i].at, sb[i].val);
            end
            sb.delete();
         end
      end
   end

   // Main schedule, indexed by k = cycle offset from the first src0 edge.
   function automatic logic s0(input int k);
      if (k < 0)   return 1'b0;
      if (k < 108) return ((k / 6) % 2) == 0;
      return k != 140;
   endfunction

   function automatic logic s1(input int k);
      if (k >= 50 && k < 60) return (((k - 50) / 5) % 2) == 0;
      return 1'b0;
   endfunction

   function automatic logic s2(input int k);
      if (k < 36)  return 1'b0;
      if (k >= 68) return 1'b1;
      return (((k - 36) / 4) % 2) == 0;
   endfunction

   function automatic int vol(input int k);
      return (k < 135) ? 7 : 1;
   endfunction

   function automatic logic mt(input int k);
      return (k >= 152) && (k < 160);
   endfunction

   // hand-derived FSM state after edge q: 0 IDLE, 1 PLAY, 2 GAP
   function automatic int stAt(input int q);
      if (q >= 3   && q <= 38)  return 1;
      if (q >= 39  && q <= 42)  return 2;
      if (q >= 43  && q <= 90)  return 1;
      if (q >= 91  && q <= 94)  return 2;
      if (q >= 95  && q <= 130) return 1;
      if (q >= 143 && q <= 163) return 1;
      return 0;
   endfunction

   function automatic int ownAt(input int q);
      return (q >= 39 && q <= 90) ? 2 : 0;
   endfunction

   function automatic logic srcOf(input int k, input int o);
      case (o)
         0:       return s0(k);
         1:       return s1(k);
         default: return s2(k);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expectResetNow(input string tag);
      expectAt(-1, 0, 0, {tag, " speaker_out"});
      expectAt(-1, 1, 0, {tag, " busy"});
      expectAt(-1, 2, 0, {tag, " active_src"});
      ->chkEv;
      #1;
   endtask

   initial begin : stimulus
      logic spk;
      logic b;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         src_sound = 3'($urandom_range(0, 7));
         tick();
         expectResetNow("in reset");
      end
      src_sound = '0;
      #1 rst_n = 1'b1;

      // idle, single source, preemption, fallback, idle, volume, mute
      for (int k = -6; k < 175; k++) begin
         tick();
         src_sound = {s2(k), s1(k), s0(k)};
         volume    = 3'(vol(k));
         mute      = mt(k);
         spk = (stAt(k + 1) == 1) && srcOf(k, ownAt(k + 1)) &&
               (((cyc + 1) % 8) <= vol(k + 1)) && !mt(k + 1);
         expectAt(cyc + 2, 0, int'(spk), "speaker_out");
         expectAt(cyc + 2, 1, int'(stAt(k + 2) != 0), "busy");
         expectAt(cyc + 2, 2, ownAt(k + 2), "active_src");
      end
      tick();
      tick();

      // reset asserted in the middle of a gap
      volume = 3'd7;
      mute   = 1'b0;
      src_sound[0] = 1'b0;
      expectAt(cyc + 2, 1, 0, "busy before play");
      expectAt(cyc + 3, 1, 1, "busy at play");
      expectAt(cyc + 3, 2, 0, "owner at play");
      repeat (4) tick();
      src_sound[2] = 1'b0;
      expectAt(cyc + 3, 2, 2, "gap owner");
      expectAt(cyc + 3, 1, 1, "gap busy");
      expectAt(cyc + 3, 0, 0, "gap speaker_out");
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      expectResetNow("reset mid-gap");
      for (int i = 0; i < 2; i++) begin
         src_sound = 3'($urandom_range(0, 7));
         tick();
      end
      src_sound = '0;
      rst_n = 1'b1;

      // two sources wake together: higher index owns, no gap from idle
      for (int j = 0; j < 14; j++) begin
         tick();
         b = ((j / 3) % 2) == 0;
         src_sound = {1'b0, b, 1'b1};
         expectAt(cyc + 2, 0, (j >= 2) ? int'(b) : 0, "restart speaker_out");
         expectAt(cyc + 2, 1, (j >= 1) ? 1 : 0, "restart busy");
         expectAt(cyc + 2, 2, (j >= 1) ? 1 : 0, "restart active_src");
      end
      repeat (3) tick();

      finalChk = 1'b1;
      ->chkEv;
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
